// File: rtl/qpu_ifu_pkg.sv
// Shared types and helpers for the QPU instruction fetch unit.
package qpu_ifu_pkg;

  localparam int unsigned PcWDef    = 32;
  localparam int unsigned InstrWDef = 32;

  typedef struct packed {
    logic [InstrWDef-1:0] instr;
    logic [PcWDef-1:0]    pc;
  } ibuf_entry_t;

  // Bits needed to hold a count in the range 0..n.
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/qpu_sync_fifo.sv
// Synchronous FIFO with clear and occupancy count; clear wins over push/pop.
module qpu_sync_fifo
  import qpu_ifu_pkg::*;
#(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      clr_i,
  input  logic                      push_i,
  input  logic [Width-1:0]          wdata_i,
  input  logic                      pop_i,
  output logic [Width-1:0]          rdata_o,
  output logic                      empty_o,
  output logic [cnt_w(Depth)-1:0]   count_o
);

  localparam int unsigned CntW = cnt_w(Depth);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign do_push = push_i & (cnt_q != CntW'(Depth));
  assign do_pop  = pop_i & (cnt_q != '0);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (clr_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (do_push) wptr_d = ptr_inc(wptr_q);
      if (do_pop)  rptr_d = ptr_inc(rptr_q);
      cnt_d = cnt_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !clr_i && !rst_i) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/qpu_ifu_ifetch_mo.sv
// Multi-outstanding sequential instruction fetch with credit-based issue,
// precise flush (stale responses dropped by count) and halt handshake.
module qpu_ifu_ifetch_mo
  import qpu_ifu_pkg::*;
#(
  parameter int unsigned PC_W       = PcWDef,
  parameter int unsigned INSTR_W    = InstrWDef,
  parameter int unsigned MAX_OUTS   = 4,
  parameter int unsigned IBUF_DEPTH = 4,
  parameter int unsigned PC_INCR    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PC_W-1:0]    pc_rtvec,
  output logic               ifu_req_valid,
  input  logic               ifu_req_ready,
  output logic [PC_W-1:0]    ifu_req_pc,
  input  logic               ifu_rsp_valid,
  output logic               ifu_rsp_ready,
  input  logic [INSTR_W-1:0] ifu_rsp_instr,
  output logic               ifu_o_valid,
  input  logic               ifu_o_ready,
  output logic [INSTR_W-1:0] ifu_o_ir,
  output logic [PC_W-1:0]    ifu_o_pc,
  input  logic               pipe_flush_req,
  input  logic [PC_W-1:0]    pipe_flush_pc,
  input  logic               ifu_halt_req,
  output logic               ifu_halt_ack,
  output logic [PC_W-1:0]    inspect_pc
);

  localparam int unsigned OutsW = cnt_w(MAX_OUTS);
  localparam int unsigned IbW   = cnt_w(IBUF_DEPTH);

  logic [PC_W-1:0]  pc_q, pc_d;
  logic [OutsW-1:0] outs_q, outs_d, drop_q, drop_d;
  logic             halt_ack_q, halt_ack_d;

  logic             req_hs, rsp_hs, ibuf_push, ibuf_pop;
  logic [PC_W-1:0]  pcq_head;
  logic             pcq_empty, ibuf_empty;
  logic [OutsW-1:0] pcq_cnt;
  logic [IbW-1:0]   ibuf_cnt;
  ibuf_entry_t      ibuf_wentry, ibuf_head;

  // Credit: every in-flight request already owns a buffer slot.
  assign ifu_req_valid = ~rst & ~pipe_flush_req & ~ifu_halt_req
                       & (32'(outs_q) < MAX_OUTS)
                       & ((32'(outs_q) + 32'(ibuf_cnt)) < IBUF_DEPTH);
  assign ifu_req_pc    = pc_q;
  assign req_hs        = ifu_req_valid & ifu_req_ready;

  assign ifu_rsp_ready = ~rst;
  assign rsp_hs        = ifu_rsp_valid & ~rst;
  assign ibuf_push     = rsp_hs & ~pipe_flush_req & (drop_q == '0);

  assign ifu_o_valid   = ~ibuf_empty & ~pipe_flush_req & ~rst;
  assign ibuf_pop      = ifu_o_valid & ifu_o_ready;
  assign ifu_o_ir      = ibuf_head.instr;
  assign ifu_o_pc      = ibuf_head.pc;

  assign ibuf_wentry.instr = ifu_rsp_instr;
  assign ibuf_wentry.pc    = pcq_head;

  assign ifu_halt_ack = halt_ack_q;
  assign inspect_pc   = pc_q;

  always_comb begin
    pc_d       = pc_q;
    drop_d     = drop_q;
    outs_d     = outs_q + OutsW'(req_hs) - OutsW'(rsp_hs);
    halt_ack_d = ifu_halt_req & (outs_q == '0);
    if (pipe_flush_req) begin
      pc_d   = {pipe_flush_pc[PC_W-1:1], 1'b0};
      // Everything still outstanding after this cycle is stale.
      drop_d = outs_q - OutsW'(rsp_hs);
    end else begin
      if (req_hs) pc_d = pc_q + PC_W'(PC_INCR);
      if (rsp_hs && drop_q != '0) drop_d = drop_q - OutsW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= pc_rtvec;
      outs_q     <= '0;
      drop_q     <= '0;
      halt_ack_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      outs_q     <= outs_d;
      drop_q     <= drop_d;
      halt_ack_q <= halt_ack_d;
    end
  end

  qpu_sync_fifo #(
    .Width (PC_W),
    .Depth (MAX_OUTS)
  ) u_pc_queue (
    .clk_i   (clk),
    .rst_i   (rst),
    .clr_i   (1'b0),
    .push_i  (req_hs),
    .wdata_i (pc_q),
    .pop_i   (rsp_hs),
    .rdata_o (pcq_head),
    .empty_o (pcq_empty),
    .count_o (pcq_cnt)
  );

  qpu_sync_fifo #(
    .Width ($bits(ibuf_entry_t)),
    .Depth (IBUF_DEPTH)
  ) u_ibuf (
    .clk_i   (clk),
    .rst_i   (rst),
    .clr_i   (pipe_flush_req),
    .push_i  (ibuf_push),
    .wdata_i (ibuf_wentry),
    .pop_i   (ibuf_pop),
    .rdata_o (ibuf_head),
    .empty_o (ibuf_empty),
    .count_o (ibuf_cnt)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(ifu_rsp_valid && outs_q == '0));
      assert (drop_q <= outs_q);
      assert (pcq_cnt == outs_q);
      assert (pcq_empty == (outs_q == '0));
    end
  end

endmodule
